// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD-host data-line engine.
package sd_dat_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRdStart,
    StRdShift,
    StRdPush,
    StRdStop,
    StWrFetch,
    StWrStart,
    StWrShift,
    StWrStop,
    StWrBusy,
    StDone
  } sd_state_e;

  localparam logic Bus4 = 1'b1;
  localparam logic Bus1 = 1'b0;

  localparam int unsigned BlockWordsDefault = 128;
  localparam logic [3:0]  IdleNibble        = 4'hF;

  // Lines that carry data for the given bus width.
  function automatic logic [3:0] active_mask(input logic bus_width);
    return (bus_width == Bus4) ? 4'hF : 4'h1;
  endfunction

endpackage

// File: rtl/sd_dat_shifter.sv
// 32-bit MSB-first shift register stepping 1 or 4 bits, with a per-word step counter.
module sd_dat_shifter
  import sd_dat_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_word_i,
  input  logic        shift_i,
  input  logic        bus4_i,
  input  logic [3:0]  din_i,
  output logic [31:0] next_word_o,
  output logic [3:0]  dout_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [4:0]  cnt_q, cnt_d;

  assign last_o      = (cnt_q == ((bus4_i == Bus4) ? 5'd7 : 5'd31));
  assign next_word_o = (bus4_i == Bus4) ? {word_q[27:0], din_i} : {word_q[30:0], din_i[0]};
  // Unused lines stay high in 1-bit mode.
  assign dout_o      = (bus4_i == Bus4) ? word_q[31:28] : {3'b111, word_q[31]};

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = load_word_i;
      cnt_d  = 5'd0;
    end else if (shift_i) begin
      word_d = next_word_o;
      cnt_d  = last_o ? 5'd0 : cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= 32'h0;
      cnt_q  <= 5'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_dat.sv
// SD-host data-line engine: multi-block transfers between the host FIFO and DAT[3:0].
module sd_dat
  import sd_dat_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = BlockWordsDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_trans,
  input  logic        mode,
  input  logic        direction,
  input  logic [10:0] block_amount,
  input  logic [3:0]  card_in,
  output logic [3:0]  card_out,
  input  logic        card_ack_i,
  output logic        card_ack_o,
  input  logic [31:0] buffer_in,
  output logic [31:0] buffer_out,
  output logic        fifo_enable_o,
  input  logic        fifo_ack_i,
  output logic        fifo_ack_o,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        fifo_ready
);

  localparam int unsigned WordCntW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  sd_state_e         state_q;
  logic              bus4_q;
  logic [10:0]       amount_q;
  logic [10:0]       blk_cnt_q;
  logic [WordCntW-1:0] word_cnt_q;
  logic [3:0]        card_out_q;
  logic [31:0]       buffer_out_q;
  logic              fifo_en_q, fifo_ack_q, card_ack_q, ready_q;

  logic [31:0] sh_next;
  logic [3:0]  sh_dout;
  logic        sh_last, sh_load, sh_shift;
  logic        last_word, last_blk, fifo_hs;

  assign last_word = (word_cnt_q == WordCntW'(BLOCK_WORDS - 1));
  assign last_blk  = (blk_cnt_q == amount_q - 11'd1);
  assign fifo_hs   = fifo_en_q && fifo_ack_i;
  assign sh_load   = (state_q == StWrFetch) && fifo_hs;
  assign sh_shift  = (state_q == StRdShift) || (state_q == StWrShift);

  sd_dat_shifter u_shifter (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (sh_load),
    .load_word_i (buffer_in),
    .shift_i     (sh_shift),
    .bus4_i      (bus4_q),
    .din_i       (card_in),
    .next_word_o (sh_next),
    .dout_o      (sh_dout),
    .last_o      (sh_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      bus4_q       <= Bus1;
      amount_q     <= 11'd0;
      blk_cnt_q    <= 11'd0;
      word_cnt_q   <= '0;
      card_out_q   <= IdleNibble;
      buffer_out_q <= 32'h0;
      fifo_en_q    <= 1'b0;
      fifo_ack_q   <= 1'b0;
      card_ack_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      fifo_ack_q <= 1'b0;
      card_ack_q <= 1'b0;
      ready_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          card_out_q <= IdleNibble;
          if (new_trans) begin
            bus4_q     <= mode;
            amount_q   <= block_amount;
            blk_cnt_q  <= 11'd0;
            word_cnt_q <= '0;
            if (block_amount == 11'd0) state_q <= StDone;
            else                       state_q <= direction ? StRdStart : StWrFetch;
          end
        end
        StRdStart: begin
          if ((card_in & active_mask(bus4_q)) == 4'h0) state_q <= StRdShift;
        end
        StRdShift: begin
          if (sh_last) begin
            buffer_out_q <= sh_next;
            fifo_en_q    <= !fifo_full;
            state_q      <= StRdPush;
          end
        end
        StRdPush: begin
          // An acknowledge is honoured even if fifo_full rises in the same cycle.
          if (fifo_hs) begin
            fifo_en_q <= 1'b0;
            if (last_word) begin
              word_cnt_q <= '0;
              state_q    <= StRdStop;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
              state_q    <= StRdShift;
            end
          end else begin
            fifo_en_q <= !fifo_full;
          end
        end
        StRdStop: begin
          card_ack_q <= 1'b1;
          if (last_blk) begin
            state_q <= StDone;
          end else begin
            blk_cnt_q <= blk_cnt_q + 11'd1;
            state_q   <= StRdStart;
          end
        end
        StWrFetch: begin
          card_out_q <= IdleNibble;
          if (fifo_hs) begin
            fifo_en_q  <= 1'b0;
            fifo_ack_q <= 1'b1;
            state_q    <= (word_cnt_q == '0) ? StWrStart : StWrShift;
          end else begin
            fifo_en_q <= !fifo_empty;
          end
        end
        StWrStart: begin
          card_out_q <= ~active_mask(bus4_q);
          state_q    <= StWrShift;
        end
        StWrShift: begin
          card_out_q <= sh_dout;
          if (sh_last) begin
            if (last_word) begin
              word_cnt_q <= '0;
              state_q    <= StWrStop;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
              state_q    <= StWrFetch;
            end
          end
        end
        StWrStop: begin
          card_out_q <= IdleNibble;
          card_ack_q <= 1'b1;
          state_q    <= StWrBusy;
        end
        StWrBusy: begin
          if (card_ack_i) begin
            if (last_blk) begin
              state_q <= StDone;
            end else begin
              blk_cnt_q <= blk_cnt_q + 11'd1;
              state_q   <= StWrFetch;
            end
          end
        end
        StDone: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign card_out      = card_out_q;
  assign buffer_out    = buffer_out_q;
  assign fifo_enable_o = fifo_en_q;
  assign fifo_ack_o    = fifo_ack_q;
  assign card_ack_o    = card_ack_q;
  assign fifo_ready    = ready_q;

endmodule

// File: tb/tb_sd_dat.sv
// Directed/randomised bench for sd_dat; expected DAT symbols derive from each word's bit order.
module tb_sd_dat;

  localparam int unsigned BW = 2;

  logic        clock = 1'b0;
  logic        reset, new_trans, mode, direction;
  logic [10:0] block_amount;
  logic [3:0]  card_in, card_out;
  logic        card_ack_i, card_ack_o;
  logic [31:0] buffer_in, buffer_out;
  logic        fifo_enable_o, fifo_ack_i, fifo_ack_o, fifo_full, fifo_empty, fifo_ready;

  int tests = 0;
  int fails = 0;
  logic [31:0] pat[$];

  always #5 clock = ~clock;

  sd_dat #(.BLOCK_WORDS(BW)) dut (
    .clock         (clock),
    .reset         (reset),
    .new_trans     (new_trans),
    .mode          (mode),
    .direction     (direction),
    .block_amount  (block_amount),
    .card_in       (card_in),
    .card_out      (card_out),
    .card_ack_i    (card_ack_i),
    .card_ack_o    (card_ack_o),
    .buffer_in     (buffer_in),
    .buffer_out    (buffer_out),
    .fifo_enable_o (fifo_enable_o),
    .fifo_ack_i    (fifo_ack_i),
    .fifo_ack_o    (fifo_ack_o),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_ready    (fifo_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_word();
    logic [31:0] w;
    if (pat.size() > 0) w = pat.pop_front();
    else                w = $urandom;
    return w;
  endfunction

  // k-th DAT symbol of a word as the card sees it.
  function automatic logic [3:0] symbol(input logic [31:0] w, input logic md, input int k);
    logic [3:0] s;
    if (md) s = w[31-4*k -: 4];
    else    s = {3'b111, w[31-k]};
    return s;
  endfunction

  task automatic start_xfer(input logic dir, input logic md, input int nblk);
    direction    = dir;
    mode         = md;
    block_amount = 11'(nblk);
    new_trans    = 1'b1;
    @(negedge clock);
    new_trans = 1'b0;
    direction = ~dir;
    mode      = ~md;
  endtask

  task automatic rd_xfer(input logic md, input int nblk, input int stall);
    logic [31:0] w;
    logic [3:0]  c;
    int          nsym;
    nsym = md ? 8 : 32;
    start_xfer(1'b1, md, nblk);
    for (int b = 0; b < nblk; b++) begin
      c = 4'($urandom);
      card_in = md ? 4'h0 : {c[3:1], 1'b0};
      @(negedge clock);
      for (int i = 0; i < int'(BW); i++) begin
        w = next_word();
        for (int k = 0; k < nsym; k++) begin
          c = 4'($urandom);
          card_in = md ? w[31-4*k -: 4] : {c[3:1], w[31-k]};
          if (k == nsym - 1 && stall > 0) fifo_full = 1'b1;
          @(negedge clock);
        end
        chk("rd_word", buffer_out, w);
        for (int s = 0; s < stall; s++) begin
          chk("rd_stall_en", 32'(fifo_enable_o), 32'd0);
          card_in = 4'($urandom);
          if (s == stall - 1) fifo_full = 1'b0;
          @(negedge clock);
        end
        chk("rd_push_en", 32'(fifo_enable_o), 32'd1);
        fifo_ack_i = 1'b1;
        card_in    = 4'($urandom);
        @(negedge clock);
        fifo_ack_i = 1'b0;
        chk("rd_push_drop", 32'(fifo_enable_o), 32'd0);
      end
      card_in = 4'hF;
      chk("rd_no_early_ack", 32'(card_ack_o), 32'd0);
      @(negedge clock);
      chk("rd_card_ack", 32'(card_ack_o), 32'd1);
    end
    chk("rd_ready_early", 32'(fifo_ready), 32'd0);
    @(negedge clock);
    chk("rd_ready", 32'(fifo_ready), 32'd1);
    chk("rd_ack_single", 32'(card_ack_o), 32'd0);
  endtask

  task automatic wr_xfer(input logic md, input int nblk, input int gap, input int busy);
    logic [31:0] w;
    int          n;
    int          nsym;
    nsym = md ? 8 : 32;
    start_xfer(1'b0, md, nblk);
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < int'(BW); i++) begin
        if (i > 0 && gap > 0) begin
          fifo_empty = 1'b1;
          for (int s = 0; s < gap; s++) begin
            @(negedge clock);
            chk("wr_gap_en", 32'(fifo_enable_o), 32'd0);
            chk("wr_gap_idle", 32'(card_out), 32'hF);
          end
          fifo_empty = 1'b0;
        end
        n = 0;
        while (!fifo_enable_o && n < 20) begin
          @(negedge clock);
          n++;
        end
        chk("wr_fetch_en", 32'(fifo_enable_o), 32'd1);
        w          = next_word();
        buffer_in  = w;
        fifo_ack_i = 1'b1;
        @(negedge clock);
        fifo_ack_i = 1'b0;
        buffer_in  = $urandom;
        chk("wr_fifo_ack", 32'(fifo_ack_o), 32'd1);
        if (i == 0) begin
          @(negedge clock);
          chk("wr_start", 32'(card_out), md ? 32'h0 : 32'hE);
        end
        for (int k = 0; k < nsym; k++) begin
          @(negedge clock);
          if (k == 0) chk("wr_fifo_ack_pulse", 32'(fifo_ack_o), 32'd0);
          chk("wr_sym", 32'(card_out), 32'(symbol(w, md, k)));
        end
      end
      card_ack_i = (busy == 0);
      @(negedge clock);
      chk("wr_stop", 32'(card_out), 32'hF);
      chk("wr_card_ack", 32'(card_ack_o), 32'd1);
      for (int s = 0; s < busy; s++) begin
        @(negedge clock);
        chk("wr_busy_en", 32'(fifo_enable_o), 32'd0);
        chk("wr_busy_idle", 32'(card_out), 32'hF);
      end
      card_ack_i = 1'b1;
    end
    @(negedge clock);
    chk("wr_ready_early", 32'(fifo_ready), 32'd0);
    @(negedge clock);
    chk("wr_ready", 32'(fifo_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (observed running, required done)");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    int   n;
    reset = 1'b1;  new_trans = 1'b0; mode = 1'b1; direction = 1'b0; block_amount = 11'd0;
    card_in = 4'hF; card_ack_i = 1'b1; buffer_in = 32'h0; fifo_ack_i = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_card_out", 32'(card_out), 32'hF);
    chk("rst_buffer_out", buffer_out, 32'h0);
    chk("rst_strobes", {28'h0, fifo_enable_o, fifo_ack_o, card_ack_o, fifo_ready}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    pat = '{32'h12345678, 32'h9ABCDEF0};
    rd_xfer(1'b1, 1, 0);
    pat = '{32'hA5A5A5A5};
    rd_xfer(1'b0, 1, 0);
    rd_xfer(1'b1, 2, 5);
    rd_xfer(1'b0, 1, 2);

    pat = '{32'hDEADBEEF};
    wr_xfer(1'b1, 1, 0, 0);
    wr_xfer(1'b1, 2, 3, 10);
    wr_xfer(1'b0, 1, 0, 0);
    wr_xfer(1'b0, 2, 2, 3);

    // Zero blocks completes immediately.
    start_xfer(1'b1, 1'b1, 0);
    chk("zero_ready_early", 32'(fifo_ready), 32'd0);
    @(negedge clock);
    chk("zero_ready", 32'(fifo_ready), 32'd1);
    @(negedge clock);

    // Reset in the middle of a written word.
    start_xfer(1'b0, 1'b1, 1);
    n = 0;
    while (!fifo_enable_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("mid_fetch_en", 32'(fifo_enable_o), 32'd1);
    buffer_in  = 32'h0000_0000;
    fifo_ack_i = 1'b1;
    @(negedge clock);
    fifo_ack_i = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_driving", 32'(card_out), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_card_out", 32'(card_out), 32'hF);
    chk("mid_rst_strobes", {29'h0, fifo_enable_o, fifo_ack_o, card_ack_o}, 32'h0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | fifo_ready | card_ack_o | (card_out != 4'hF);
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
